// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU op sequencer: op code constants, FSM state
// encoding and op classification helpers.
package alu_seq_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b00101;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b00110;
  localparam logic [OPC_W-1:0] OP_AND = 5'b01000;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b10010;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Y = 3'd1,
    S_EXEC   = 3'd2,
    S_WB_LO  = 3'd3,
    S_WB_HI  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // Unary ops take their only operand from rb and skip the Y load.
  function automatic logic is_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  // Ops with a 64-bit result written back to the HI/LO pair.
  function automatic logic is_hilo(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal(input logic [OPC_W-1:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SHR, OP_ROL, OP_AND, OP_OR,
                      OP_MUL, OP_DIV, OP_NEG, OP_NOT};
  endfunction

endpackage

// File: rtl/alu_op_sequencer_onehot_dec.sv
// Register index to one-hot enable decoder; all zeros when en is low.
module onehot_dec #(
  parameter int NUM_REGS = 16
) (
  input  logic [3:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // NOTE: the '0 default ahead of the loop keeps every bit assigned on every
  // path, so no latch is inferred.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (int'(idx) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Strobe sequencer for one register-register ALU instruction per start pulse.
// Optional build macro ALUSEQ_R0_GUARD_EN suppresses register writes to R0.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                Clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OP_W-1:0]     opcode,
  input  logic [3:0]          ra,
  input  logic [3:0]          rb,
  input  logic [3:0]          rc,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [OP_W-1:0]     op_out,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic                Yin,
  output logic                ZHighin,
  output logic                Zlowin,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                HIin,
  output logic                Loin
);

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic [3:0]      ra_q;
  logic [3:0]      rc_q;

  logic            rout_en;
  logic [3:0]      rout_idx;
  logic            rin_en;
  logic [3:0]      rin_idx;

  logic            in_legal;
  logic            in_unary;
  logic            q_hilo;
  logic            wr_ok;

  assign in_legal = is_legal(OPC_W'(opcode));
  assign in_unary = is_unary(OPC_W'(opcode));
  assign q_hilo   = is_hilo(OPC_W'(op_q));

`ifdef ALUSEQ_R0_GUARD_EN
  // R0 is hardwired: the write strobe is dropped, the bus cycle still happens.
  assign wr_ok = (ra_q != 4'd0);
`else
  assign wr_ok = 1'b1;
`endif

  // Each branch loads the outputs belonging to the state being entered, so
  // every strobe is a clean register output held for exactly one cycle.
  // NOTE: sequential state uses non-blocking assignments only; later
  // assignments in the same pass override the defaults at the top.
  // NOTE: the captured instruction fields are not reset; they are only read
  // in states that are reachable after a capture.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      op_out   <= '0;
      Yin      <= 1'b0;
      ZHighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighout <= 1'b0;
      Zlowout  <= 1'b0;
      HIin     <= 1'b0;
      Loin     <= 1'b0;
      rout_en  <= 1'b0;
      rout_idx <= '0;
      rin_en   <= 1'b0;
      rin_idx  <= '0;
    end else begin
      done     <= 1'b0;
      illegal  <= 1'b0;
      op_out   <= '0;
      Yin      <= 1'b0;
      ZHighin  <= 1'b0;
      Zlowin   <= 1'b0;
      Zhighout <= 1'b0;
      Zlowout  <= 1'b0;
      HIin     <= 1'b0;
      Loin     <= 1'b0;
      rout_en  <= 1'b0;
      rin_en   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= opcode;
            ra_q <= ra;
            rc_q <= rc;
            busy <= 1'b1;
            if (!in_legal) begin
              state   <= S_DONE;
              done    <= 1'b1;
              illegal <= 1'b1;
            end else if (in_unary) begin
              state    <= S_EXEC;
              op_out   <= opcode;
              ZHighin  <= 1'b1;
              Zlowin   <= 1'b1;
              rout_en  <= 1'b1;
              rout_idx <= rb;
            end else begin
              state    <= S_LOAD_Y;
              op_out   <= opcode;
              Yin      <= 1'b1;
              rout_en  <= 1'b1;
              rout_idx <= rb;
            end
          end
        end

        S_LOAD_Y: begin
          state    <= S_EXEC;
          op_out   <= op_q;
          ZHighin  <= 1'b1;
          Zlowin   <= 1'b1;
          rout_en  <= 1'b1;
          rout_idx <= rc_q;
        end

        S_EXEC: begin
          state   <= S_WB_LO;
          Zlowout <= 1'b1;
          if (q_hilo) begin
            Loin <= 1'b1;
          end else begin
            rin_en  <= wr_ok;
            rin_idx <= ra_q;
          end
        end

        S_WB_LO: begin
          if (q_hilo) begin
            state    <= S_WB_HI;
            Zhighout <= 1'b1;
            HIin     <= 1'b1;
          end else begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end

        S_WB_HI: begin
          state <= S_DONE;
          done  <= 1'b1;
        end

        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  onehot_dec #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  onehot_dec #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .idx    (rin_idx),
    .en     (rin_en),
    .onehot (Rin)
  );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized bench for alu_op_sequencer: each instruction is expanded into
// its expected per-cycle output vectors and compared cycle by cycle.
module tb_alu_op_sequencer;

  logic        Clock = 1'b0;
  logic        clear;
  logic        start;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        busy, done, illegal;
  logic [4:0]  op_out;
  logic [15:0] Rout, Rin;
  logic        Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, Loin;

  always #5 Clock = ~Clock;

  alu_op_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
    .Clock    (Clock),
    .clear    (clear),
    .start    (start),
    .opcode   (opcode),
    .ra       (ra),
    .rb       (rb),
    .rc       (rc),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal),
    .op_out   (op_out),
    .Rout     (Rout),
    .Rin      (Rin),
    .Yin      (Yin),
    .ZHighin  (ZHighin),
    .Zlowin   (Zlowin),
    .Zhighout (Zhighout),
    .Zlowout  (Zlowout),
    .HIin     (HIin),
    .Loin     (Loin)
  );

  // {busy,done,illegal,op_out,Rout,Rin,Yin,ZHighin,Zlowin,Zhighout,Zlowout,HIin,Loin}
  typedef logic [46:0] vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t exp_q[$];
  logic [4:0] legal_ops [10] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                                 5'd15, 5'd16, 5'd17, 5'd18};

  task automatic check(input string tag, input vec_t got, input vec_t want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic vec_t observed();
    return {busy, done, illegal, op_out, Rout, Rin,
            Yin, ZHighin, Zlowin, Zhighout, Zlowout, HIin, Loin};
  endfunction

  function automatic vec_t mk(input logic b, input logic d, input logic il,
                              input logic [4:0] op, input logic [15:0] ro,
                              input logic [15:0] ri, input logic [6:0] strobes);
    return {b, d, il, op, ro, ri, strobes};
  endfunction

  // strobes field order: Yin ZHighin Zlowin Zhighout Zlowout HIin Loin
  task automatic build(input logic [4:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] c);
    bit          legal = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                                    5'd15, 5'd16, 5'd17, 5'd18};
    bit          unary = op inside {5'd17, 5'd18};
    bit          hilo  = op inside {5'd15, 5'd16};
    logic [15:0] wr    = 16'h1 << a;
`ifdef ALUSEQ_R0_GUARD_EN
    if (a == 4'd0) wr = 16'h0;
`endif
    exp_q.delete();
    if (!legal) begin
      exp_q.push_back(mk(1, 1, 1, 5'd0, 16'h0, 16'h0, 7'b0000000));
    end else begin
      if (!unary) exp_q.push_back(mk(1, 0, 0, op, 16'h1 << b, 16'h0, 7'b1000000));
      exp_q.push_back(mk(1, 0, 0, op, 16'h1 << (unary ? b : c), 16'h0, 7'b0110000));
      if (hilo) begin
        exp_q.push_back(mk(1, 0, 0, 5'd0, 16'h0, 16'h0, 7'b0000101));
        exp_q.push_back(mk(1, 0, 0, 5'd0, 16'h0, 16'h0, 7'b0001010));
      end else begin
        exp_q.push_back(mk(1, 0, 0, 5'd0, 16'h0, wr, 7'b0000100));
      end
      exp_q.push_back(mk(1, 1, 0, 5'd0, 16'h0, 16'h0, 7'b0000000));
    end
  endtask

  task automatic scramble_inputs();
    start  = 1'($urandom_range(0, 1));
    opcode = 5'($urandom_range(0, 31));
    ra     = 4'($urandom_range(0, 15));
    rb     = 4'($urandom_range(0, 15));
    rc     = 4'($urandom_range(0, 15));
  endtask

  // Starts at a falling edge; abort_at >= 0 raises clear after that cycle.
  task automatic run_op(input logic [4:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] c,
                        input int abort_at, input string tag);
    build(op, a, b, c);
    opcode = op; ra = a; rb = b; rc = c; start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      check($sformatf("%s cyc k+%0d", tag, i + 1), observed(), exp_q[i]);
      scramble_inputs();
      if (i == abort_at) begin
        clear = 1'b1;
        @(negedge Clock);
        clear = 1'b0;
        start = 1'b0;
        check($sformatf("%s after clear", tag), observed(), '0);
        return;
      end
    end
    @(negedge Clock);
    check($sformatf("%s back to idle", tag), observed(), '0);
    start = 1'b0;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
    repeat (2) @(negedge Clock);
    check("reset", observed(), '0);
    clear = 1'b0;
    @(negedge Clock);
    check("idle after reset", observed(), '0);

    run_op(5'b00110, 4'd1, 4'd3, 4'd2, -1, "rol");
    run_op(5'b10010, 4'd4, 4'd5, 4'd0, -1, "not");
    run_op(5'b01111, 4'd1, 4'd2, 4'd3, -1, "mul");
    run_op(5'b11111, 4'd1, 4'd2, 4'd3, -1, "illegal");
    run_op(5'b00011, 4'd0, 4'd1, 4'd2, -1, "add_r0");
    run_op(5'b00011, 4'd1, 4'd2, 4'd3, 1,  "clear_in_exec");
    run_op(5'b00100, 4'd7, 4'd7, 4'd7, -1, "sub_after_clear");
    run_op(5'b10000, 4'd9, 4'd15, 4'd0, -1, "div");

    for (int n = 0; n < 300; n++) begin
      logic [4:0] op;
      int         abort_at;
      op       = ($urandom_range(0, 99) < 85) ? legal_ops[$urandom_range(0, 9)]
                                              : 5'($urandom_range(0, 31));
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_op(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), abort_at, $sformatf("rnd%0d op%0d", n, op));
      repeat ($urandom_range(0, 2)) begin
        @(negedge Clock);
        check($sformatf("rnd%0d gap", n), observed(), '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Control sequencer that sits directly upstream of data_path.
- Accepts one decoded register-register ALU instruction per start pulse.
- Drives the datapath strobes in order: register out, Yin, op, ZHighin/Zlowin, Zlowout/Zhighout, register in.
- Replaces hand-stepped testbench sequencing of ALU operations such as ROL, including writeback to HI/LO for MUL/DIV.

Parameters:
- NUM_REGS, 16, number of general registers; sets width of Rout/Rin one-hot buses.
- OP_W, 5, width of ALU op code driven to data_path.

Ports:
- Clock in 1: system clock; all state changes on rising edge.
- clear in 1: synchronous reset, active-high.
- start in 1: request to execute the presented instruction; sampled only in IDLE.
- opcode in OP_W: ALU operation code.
- ra in 4: destination register index.
- rb in 4: first source register index.
- rc in 4: second source register index; ignored for unary ops.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle completion pulse.
- illegal out 1: high with done when opcode is unsupported.
- op_out out OP_W: op code presented to data_path.
- Rout out NUM_REGS: one-hot register-to-bus enables.
- Rin out NUM_REGS: one-hot bus-to-register write enables.
- Yin out 1: Y register load.
- ZHighin out 1: Z high-half load.
- Zlowin out 1: Z low-half load.
- Zhighout out 1: Z high half onto bus.
- Zlowout out 1: Z low half onto bus.
- HIin out 1: HI register load.
- Loin out 1: LO register load.

Behaviour:
- Reset: on a rising edge with clear high, go to IDLE. All outputs read 0 in the following cycle, op_out included. clear overrides start and any in-progress operation; no further strobes are issued.
- Outputs are Moore-decoded from state and the latched fields. Each strobe is asserted for exactly one full cycle. At most one Rout bit and at most one Rin bit are high.
- Start capture: opcode/ra/rb/rc are latched on the edge where start=1 in IDLE. start in any other state is ignored and not queued.
- IDLE: start with a legal binary op goes to LOAD_Y. Legal unary op (NEG, NOT) goes to EXEC. Illegal op goes to DONE.
- LOAD_Y: Rout[rb]=1, Yin=1, op_out=latched op. Next state is EXEC.
- EXEC: op_out=latched op, ZHighin=1, Zlowin=1. Rout[rc] for binary ops; Rout[rb] for unary ops. Next state is WB_LO.
- WB_LO:
  - Zlowout=1.
  - MUL/DIV: Loin=1; next state is WB_HI.
  - All other ops: Rin[ra]=1; next state is DONE.
- WB_HI: Zhighout=1, HIin=1. Next state is DONE.
- DONE: done=1; illegal=1 only if entered from IDLE with an illegal op. Next state is IDLE.
- op_out is 0 in every state except LOAD_Y and EXEC.
- Latency, with start at edge k:
  - Binary non-MUL/DIV: done high in cycle k+4.
  - Unary: k+3.
  - MUL/DIV: k+5.
  - Illegal: k+1.
- A new start is accepted no earlier than the cycle after done.
- ra=rb or ra=rc is legal; the write in WB_LO occurs after both reads.

Optional Feature:
- Macro ALUSEQ_R0_GUARD_EN.
- When defined: Rin[0] is forced to 0, so writes to R0 are silently dropped. The sequence and timing are unchanged and Zlowout still pulses.
- When undefined: R0 is an ordinary destination.

Decomposition:
- Package alu_seq_pkg holds the op code constants:
  - ADD=00011, SUB=00100, SHR=00101, ROL=00110, AND=01000, OR=01001
  - MUL=01111, DIV=10000, NEG=10001, NOT=10010
- The package also holds the state encoding:
  - IDLE=0, LOAD_Y=1, EXEC=2, WB_LO=3, WB_HI=4, DONE=5
- Package helper: is_unary and is_hilo classification functions.
- One sub-module, onehot_dec: 4-bit index plus enable to NUM_REGS one-hot. Instantiated twice, once for Rout and once for Rin.

Test Plan:
- ROL: R2=5 and Y-source R3=-12 preloaded via data_path. Start opcode=00110, ra=1, rb=3, rc=2. Required response:
  - Rout=0x0008 with Yin high, then Rout=0x0004 with Z loads, then Zlowout with Rin=0x0002.
  - done at k+4.
  - R1 equals the data_path ROL result.
- NOT ra=4, rb=5: LOAD_Y is skipped; done at k+3; Yin is never asserted.
- MUL rb=2, rc=3: Loin in cycle k+3, HIin in k+4, done at k+5; no Rin bit is ever set.
- opcode=11111: done=1 and illegal=1 in cycle k+1; all strobes stay 0.
- clear asserted during EXEC: next cycle is IDLE, all outputs 0, busy=0, no Rin pulse. A fresh start afterwards completes normally.
- ALUSEQ_R0_GUARD_EN defined, ADD ra=0: Zlowout pulses and Rin stays 0. Without the macro, Rin=0x0001.
